bram_rd_arbiter: RTL and testbench
==================================

Name: bram_rd_arbiter

Overview:
Shares one single-port read-only BRAM (1-cycle registered read latency) between two read requesters, e.g. the VGA pixel-fetch pipe (port 0) and the APB readback path (port 1). Each cycle it grants at most one request, drives the BRAM address, and tracks the in-flight read so the returned word is flagged to the correct requester at fixed latency. It sits between the requesters and the BRAM instance; it has no storage for word data beyond the optional output register.

Parameters:
DATA_WIDTH, 2, BRAM word width; must match the BRAM.
ADDR_WIDTH, 4, BRAM address width; must match the BRAM.
FIXED_PRIO, 0, 1 = port 0 always wins on conflict; 0 = round-robin.
RSP_REG, 0, 1 = add an output register stage (response latency 2 instead of 1).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req0_valid_i  in  1  port 0 read request
req0_addr_i  in  ADDR_WIDTH  port 0 read address
req0_ready_o  out  1  port 0 request accepted this cycle
rsp0_valid_o  out  1  port 0 read data valid (single-cycle pulse)
rsp0_data_o  out  DATA_WIDTH  port 0 read data
req1_valid_i, req1_addr_i, req1_ready_o, rsp1_valid_o, rsp1_data_o: same as port 0, for port 1
bram_addr_o  out  ADDR_WIDTH  to the BRAM addr_i
bram_dout_i  in  DATA_WIDTH  from the BRAM dout_o

Behaviour:
- Handshake: a request is accepted on a rising edge where reqN_valid_i && reqN_ready_o. readyN is combinational from the valids and the arbitration state. At most one ready is high per cycle. No response backpressure.
- Arbitration with one valid: that port gets ready=1.
- Arbitration with both valid, FIXED_PRIO=1: port 0 wins.
- Arbitration with both valid, FIXED_PRIO=0: the port not granted last wins. last_grant is a register, reset 1 so port 0 wins the first conflict, and is updated only on an accepted request.
- With neither valid: both ready=0.
- bram_addr_o: combinational mux of the granted port's address. With no grant it holds the last granted address (addr_hold register, reset 0), so the BRAM address does not toggle when idle.
- In-flight tracking: on acceptance, register inflight_valid=1 and inflight_id=N. Otherwise inflight_valid=0.
- RSP_REG=0: rspN_valid_o = inflight_valid && inflight_id==N, one cycle after acceptance. rspN_data_o = bram_dout_i passthrough to both ports; the data is meaningful only while the corresponding valid is high.
- RSP_REG=1: valid and data are registered one more stage, so latency is 2. Per-port data registers load only when that port's response is valid. When not loading, each data register holds its last value.
- Throughput: one accepted read per cycle, back-to-back, with a fully pipelined response stream. The responses of consecutive accepts from different ports interleave in accept order.
- Reset values: all rsp*_valid_o=0; rsp*_data_o=0 (RSP_REG=1); inflight_valid=0; addr_hold=0; last_grant=1.
- Reset asserted mid-operation clears in-flight and output-stage valids immediately (asynchronously). The dropped reads produce no response after reset release.
- A request held valid across cycles is not auto-repeated. Every accept produces exactly one response.
- Parameter rule: DATA_WIDTH ≥ 1, ADDR_WIDTH ≥ 1; no other arithmetic.

Test Plan:
- Single port read, RSP_REG=0; BRAM preloaded mem[i]=i mod 4, ADDR_WIDTH=4: req0 addr=5 for 1 cycle -> ready0=1 same cycle, bram_addr_o=5, rsp0_valid=1 with data=1 next cycle, rsp1_valid stays 0.
- Conflict, FIXED_PRIO=0: both valid for 4 cycles, addr0=2, addr1=7 -> grants 0,1,0,1. Responses 2,3,2,3 on alternating ports, each one cycle after its grant.
- Conflict, FIXED_PRIO=1: both valid for 3 cycles -> port 0 granted all 3 cycles, ready1=0 throughout, no rsp1_valid.
- RSP_REG=1, back-to-back: req1 addrs 3,4,5 on consecutive cycles -> rsp1_valid high for 3 cycles starting 2 cycles after the first accept, data 3,0,1. rsp1_data holds 1 afterwards.
- Idle hold: accept addr=9, then no requests for 5 cycles -> bram_addr_o stays 9, no responses.
- Reset mid-operation: accept req0 addr=6, assert rst_i before the next edge -> rsp0_valid=0 immediately, no response after release. The first conflict after reset grants port 0.

Source files
------------

// File: rtl/bram_rd_arbiter.sv
// bram_rd_arbiter
// Two read requesters share one single-port, read-only BRAM that has a
// registered read (the data comes back one cycle after the address).
// At most one request is granted each cycle. The granted address goes to the
// BRAM, and a one-entry in-flight tag steers the returned word to the port that
// asked for it. An optional output stage adds one more cycle of latency.
// The only word storage is in that optional output stage.
module bram_rd_arbiter #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int FIXED_PRIO = 0,
    parameter int RSP_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    output logic                  req0_ready_o,
    output logic                  rsp0_valid_o,
    output logic [DATA_WIDTH-1:0] rsp0_data_o,

    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    output logic                  req1_ready_o,
    output logic                  rsp1_valid_o,
    output logic [DATA_WIDTH-1:0] rsp1_data_o,

    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    input  logic [DATA_WIDTH-1:0] bram_dout_i
);

    // Arbitration state: 1 means port 1 won the last accepted request.
    // It resets to 1, so port 0 wins the first conflict after reset.
    logic                  last_grant;
    // The address that was last presented with a grant. It keeps the BRAM
    // address steady while the arbiter is idle.
    logic [ADDR_WIDTH-1:0] addr_hold;
    // One-deep tag for the read whose data the BRAM returns this cycle.
    logic                  inflight_valid;
    logic                  inflight_id;

    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic                  rsp0_hit;
    logic                  rsp1_hit;

    // Grant at most one port. Either port wins when it is alone. On a
    // conflict, port 0 wins in fixed-priority mode; otherwise the port that
    // did not win last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        case ({req1_valid_i, req0_valid_i})
            2'b01: begin
                grant0 = 1'b1;
            end
            2'b10: begin
                grant1 = 1'b1;
            end
            2'b11: begin
                if (FIXED_PRIO != 0) begin
                    grant0 = 1'b1;
                end else if (last_grant) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end
            default: begin
                grant0 = 1'b0;
                grant1 = 1'b0;
            end
        endcase
    end

    assign grant_any    = grant0 | grant1;
    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    // Drive the BRAM address from the granted port. With no grant, present
    // the held address so the BRAM input does not toggle.
    always_comb begin
        if (grant0) begin
            bram_addr_o = req0_addr_i;
        end else if (grant1) begin
            bram_addr_o = req1_addr_i;
        end else begin
            bram_addr_o = addr_hold;
        end
    end

    // Update the round-robin pointer only when a request is actually accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (grant_any) begin
            last_grant <= grant1;
        end
    end

    // Hold the last granted address for idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_hold <= {ADDR_WIDTH{1'b0}};
        end else if (grant_any) begin
            addr_hold <= bram_addr_o;
        end
    end

    // Tag the accepted read. The valid flag lasts one cycle, matching the
    // single cycle in which the BRAM presents the word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_valid <= 1'b0;
            inflight_id    <= 1'b0;
        end else begin
            inflight_valid <= grant_any;
            if (grant_any) begin
                inflight_id <= grant1;
            end
        end
    end

    assign rsp0_hit = inflight_valid & ~inflight_id;
    assign rsp1_hit = inflight_valid &  inflight_id;

    generate
        if (RSP_REG != 0) begin : g_rsp_reg
            logic                  rsp0_valid_stage;
            logic                  rsp1_valid_stage;
            logic [DATA_WIDTH-1:0] rsp0_data_stage;
            logic [DATA_WIDTH-1:0] rsp1_data_stage;

            // Delay the response pulses by one cycle. Reset removes any
            // pending pulse at once.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rsp0_valid_stage <= 1'b0;
                    rsp1_valid_stage <= 1'b0;
                end else begin
                    rsp0_valid_stage <= rsp0_hit;
                    rsp1_valid_stage <= rsp1_hit;
                end
            end

            // Capture the word for the port that owns it. The other port's
            // register keeps its previous word.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rsp0_data_stage <= {DATA_WIDTH{1'b0}};
                    rsp1_data_stage <= {DATA_WIDTH{1'b0}};
                end else begin
                    if (rsp0_hit) begin
                        rsp0_data_stage <= bram_dout_i;
                    end
                    if (rsp1_hit) begin
                        rsp1_data_stage <= bram_dout_i;
                    end
                end
            end

            assign rsp0_valid_o = rsp0_valid_stage;
            assign rsp1_valid_o = rsp1_valid_stage;
            assign rsp0_data_o  = rsp0_data_stage;
            assign rsp1_data_o  = rsp1_data_stage;
        end else begin : g_rsp_direct
            // The BRAM output register already gives one cycle of latency.
            // Both ports see the raw word, and the valids say who owns it.
            assign rsp0_valid_o = rsp0_hit;
            assign rsp1_valid_o = rsp1_hit;
            assign rsp0_data_o  = bram_dout_i;
            assign rsp1_data_o  = bram_dout_i;
        end
    endgenerate

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Self-checking bench for bram_rd_arbiter. It runs three builds side by side
// on the same request stream:
//   [0] round-robin, direct response   [1] fixed priority, direct response
//   [2] round-robin, registered response
// Each build has its own BRAM model preloaded with mem[i] = i mod 4.
module tb_bram_rd_arbiter;
    localparam int DW = 2;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v0 = 1'b0;
    logic          v1 = 1'b0;
    logic [AW-1:0] a0 = '0;
    logic [AW-1:0] a1 = '0;

    logic          rdy0 [3];
    logic          rdy1 [3];
    logic          rv0  [3];
    logic          rv1  [3];
    logic [DW-1:0] rd0  [3];
    logic [DW-1:0] rd1  [3];
    logic [DW-1:0] bdout[3];
    logic [AW-1:0] baddr[3];

    bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0), .RSP_REG(0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_addr_i(a0), .req0_ready_o(rdy0[0]),
        .rsp0_valid_o(rv0[0]), .rsp0_data_o(rd0[0]),
        .req1_valid_i(v1), .req1_addr_i(a1), .req1_ready_o(rdy1[0]),
        .rsp1_valid_o(rv1[0]), .rsp1_data_o(rd1[0]),
        .bram_addr_o(baddr[0]), .bram_dout_i(bdout[0]));

    bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(1), .RSP_REG(0)) u_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_addr_i(a0), .req0_ready_o(rdy0[1]),
        .rsp0_valid_o(rv0[1]), .rsp0_data_o(rd0[1]),
        .req1_valid_i(v1), .req1_addr_i(a1), .req1_ready_o(rdy1[1]),
        .rsp1_valid_o(rv1[1]), .rsp1_data_o(rd1[1]),
        .bram_addr_o(baddr[1]), .bram_dout_i(bdout[1]));

    bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIXED_PRIO(0), .RSP_REG(1)) u_reg (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_addr_i(a0), .req0_ready_o(rdy0[2]),
        .rsp0_valid_o(rv0[2]), .rsp0_data_o(rd0[2]),
        .req1_valid_i(v1), .req1_addr_i(a1), .req1_ready_o(rdy1[2]),
        .rsp1_valid_o(rv1[2]), .rsp1_data_o(rd1[2]),
        .bram_addr_o(baddr[2]), .bram_dout_i(bdout[2]));

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a % 4);
    endfunction

    // BRAM models: each returns its word one clock after the address.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) bdout[k] <= mem_word(baddr[k]);
    end

    int cyc = 0;
    // Cycle counter, used for the scoreboard due times.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          port;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sbq[3][$];

    // g_rr / g_fp: expected {ready1, ready0} for the round-robin and fixed builds.
    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [1:0]    g_rr;
        logic [1:0]    g_fp;
    } vec_t;
    vec_t vecs[$];

    logic [AW-1:0] exp_hold[3];
    logic [DW-1:0] hold_d0;
    logic [DW-1:0] hold_d1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v0_i, input logic [AW-1:0] a0_i,
                                input logic v1_i, input logic [AW-1:0] a1_i,
                                input logic [1:0] grr, input logic [1:0] gfp);
        vec_t t;
        t.v0 = v0_i; t.a0 = a0_i; t.v1 = v1_i; t.a1 = a1_i; t.g_rr = grr; t.g_fp = gfp;
        return t;
    endfunction

    task automatic check_rsp();
        sb_t           e;
        logic          ev0;
        logic          ev1;
        logic [DW-1:0] ed;
        for (int k = 0; k < 3; k++) begin
            ev0 = 1'b0; ev1 = 1'b0; ed = '0;
            if (sbq[k].size() != 0 && sbq[k][0].due == cyc) begin
                e = sbq[k].pop_front();
                ev0 = ~e.port; ev1 = e.port; ed = e.data;
            end
            chk($sformatf("dut%0d rsp0_valid", k), rv0[k], ev0);
            chk($sformatf("dut%0d rsp1_valid", k), rv1[k], ev1);
            if (k == 2) begin
                if (ev0) hold_d0 = ed;
                if (ev1) hold_d1 = ed;
                chk("dut2 rsp0_data", rd0[2], hold_d0);
                chk("dut2 rsp1_data", rd1[2], hold_d1);
            end else begin
                if (ev0) chk($sformatf("dut%0d rsp0_data", k), rd0[k], ed);
                if (ev1) chk($sformatf("dut%0d rsp1_data", k), rd1[k], ed);
            end
        end
    endtask

    // Start just after a rising edge. Drive one vector, check the mid-cycle
    // outputs and push the expected responses. End just after the next edge.
    task automatic run_cycle(input vec_t t);
        logic [1:0]    g;
        logic [AW-1:0] ga;
        v0 = t.v0; a0 = t.a0; v1 = t.v1; a1 = t.a1;
        @(negedge clk);
        check_rsp();
        for (int k = 0; k < 3; k++) begin
            g = (k == 1) ? t.g_fp : t.g_rr;
            chk($sformatf("dut%0d ready0", k), rdy0[k], g[0]);
            chk($sformatf("dut%0d ready1", k), rdy1[k], g[1]);
            if (g != 2'b00) begin
                ga = g[0] ? t.a0 : t.a1;
                exp_hold[k] = ga;
                sbq[k].push_back('{due: cyc + ((k == 2) ? 2 : 1), port: g[1], data: mem_word(ga)});
            end
            chk($sformatf("dut%0d bram_addr", k), baddr[k], exp_hold[k]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) exp_hold[k] = '0;
        hold_d0 = '0;
        hold_d1 = '0;

        // Conflict from reset: the round-robin builds grant 0,1,0,1 and the
        // fixed build grants port 0 every time.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b1, 4'd2, 1'b1, 4'd7, (i % 2 == 0) ? 2'b01 : 2'b10, 2'b01));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        // Single read on port 0.
        vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'd0, 2'b01, 2'b01));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        // Back-to-back reads on port 1.
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd3, 2'b10, 2'b10));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd4, 2'b10, 2'b10));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'd5, 2'b10, 2'b10));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        // Idle hold after a read of address 9.
        vecs.push_back(mk(1'b1, 4'd9, 1'b0, 4'd0, 2'b01, 2'b01));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        // Port 0 won last, so port 1 wins this conflict in round-robin mode.
        vecs.push_back(mk(1'b1, 4'd10, 1'b1, 4'd11, 2'b10, 2'b01));
        vecs.push_back(mk(1'b1, 4'd12, 1'b1, 4'd13, 2'b01, 2'b01));
        vecs.push_back(mk(1'b0, 4'd0,  1'b1, 4'd14, 2'b10, 2'b10));
        vecs.push_back(mk(1'b1, 4'd15, 1'b0, 4'd0,  2'b01, 2'b01));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));

        // Check the reset state.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset dut%0d ready0", k), rdy0[k], 1'b0);
            chk($sformatf("reset dut%0d ready1", k), rdy1[k], 1'b0);
            chk($sformatf("reset dut%0d rsp0_valid", k), rv0[k], 1'b0);
            chk($sformatf("reset dut%0d rsp1_valid", k), rv1[k], 1'b0);
            chk($sformatf("reset dut%0d bram_addr", k), baddr[k], 4'd0);
        end
        chk("reset dut2 rsp0_data", rd0[2], 2'd0);
        chk("reset dut2 rsp1_data", rd1[2], 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_cycle(vecs[i]);

        // Reset asserted while a read is in flight.
        run_cycle(mk(1'b1, 4'd6, 1'b0, 4'd0, 2'b01, 2'b01));
        chk("pre-reset dut0 rsp0_valid", rv0[0], 1'b1);
        rst = 1'b1;
        v0 = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("async reset dut%0d rsp0_valid", k), rv0[k], 1'b0);
            chk($sformatf("async reset dut%0d rsp1_valid", k), rv1[k], 1'b0);
            sbq[k].delete();
            exp_hold[k] = '0;
        end
        hold_d0 = '0;
        hold_d1 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));
        // The first conflict after reset goes to port 0, then to port 1.
        run_cycle(mk(1'b1, 4'd1, 1'b1, 4'd8, 2'b01, 2'b01));
        run_cycle(mk(1'b1, 4'd1, 1'b1, 4'd8, 2'b10, 2'b01));
        for (int i = 0; i < 3; i++) run_cycle(mk(1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 2'b00));

        for (int k = 0; k < 3; k++)
            chk($sformatf("dut%0d outstanding responses", k), sbq[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
